// File: rtl/rle_pkg.sv
// Shared constants and types for the RLE decoder: coefficient format and FSM states.
package rle_pkg;
  localparam int BLK_N  = 8;
  localparam int COEF_W = 18;
  localparam int RUN_W  = 3;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {IDLE, ZEROS, VALUE, FILL} rle_state_t;
endpackage

// File: rtl/rle_out_reg.sv
// Output holding register: keeps coef/idx/last/valid stable until the consumer takes them.
module rle_out_reg
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [COEF_W-1:0] i_coef,
  input  logic [2:0]        i_idx,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [COEF_W-1:0] o_coef,
  output logic [2:0]        o_idx,
  output logic              o_last,
  output logic              o_free
);
  assign o_free = !o_valid || i_ready;

  // The top only asserts i_load while o_free is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_coef  <= '0;
      o_idx   <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_coef  <= i_coef;
      o_idx   <= i_idx;
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (run, value, eob) tokens into 8-coefficient blocks
// with index and last markers; sticky err on tokens that overrun the block.
module rle_decoder
  import rle_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RUN_W-1:0]         in_run,
  input  logic signed [COEF_W-1:0] in_value,
  input  logic                     in_eob,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_coef,
  output logic [2:0]               out_idx,
  output logic                     out_last,
  output logic                     err
);
  rle_state_t       r_state, w_state_nxt;
  logic [2:0]       r_pos;
  logic [RUN_W-1:0] r_zcnt;
  coef_t            r_hold;
  logic             r_en;
  logic             w_free, w_accept, w_ovf, w_close, w_emit;
  logic [3:0]       w_sum;
  coef_t            w_coef;

  assign w_sum    = {1'b0, r_pos} + {1'b0, in_run};
  assign w_ovf    = !in_eob && w_sum[3];
  // An overflowing token closes the block exactly like an eob.
  assign w_close  = in_eob || w_ovf;
  assign in_ready = r_en && (r_state == IDLE) && w_free;
  assign w_accept = in_valid && in_ready;

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_en <= 1'b0;
    else        r_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:
        if (w_accept) begin
          if (w_close)          w_state_nxt = (r_pos == 3'(BLK_N-1)) ? IDLE : FILL;
          else if (in_run == 0) w_state_nxt = IDLE;
          else if (in_run == 1) w_state_nxt = VALUE;
          else                  w_state_nxt = ZEROS;
        end
      ZEROS: if (w_free && r_zcnt == 1)             w_state_nxt = VALUE;
      VALUE: if (w_free)                            w_state_nxt = IDLE;
      FILL:  if (w_free && r_pos == 3'(BLK_N-1))    w_state_nxt = IDLE;
      default:                                      w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_emit = 1'b0;
    w_coef = '0;
    case (r_state)
      IDLE: begin
        w_emit = w_accept;
        if (!w_close && in_run == 0) w_coef = in_value;
      end
      VALUE: begin
        w_emit = w_free;
        w_coef = r_hold;
      end
      default: w_emit = w_free;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos  <= '0;
      r_zcnt <= '0;
      r_hold <= '0;
      err    <= 1'b0;
    end else begin
      if (w_emit) r_pos <= r_pos + 3'd1;
      if (w_accept && w_ovf) err <= 1'b1;
      if (w_accept && !w_close && in_run != 0) begin
        r_hold <= in_value;
        r_zcnt <= in_run - 1'b1;
      end else if (r_state == ZEROS && w_free) begin
        r_zcnt <= r_zcnt - 1'b1;
      end
    end
  end

  rle_out_reg u_out (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_emit),
    .i_coef (w_coef),
    .i_idx  (r_pos),
    .i_last (r_pos == 3'(BLK_N-1)),
    .i_ready(out_ready),
    .o_valid(out_valid),
    .o_coef (out_coef),
    .o_idx  (out_idx),
    .o_last (out_last),
    .o_free (w_free)
  );
endmodule

// File: doc/rle_decoder.md
# rle_decoder

Run-length decoder for the DCT+RLE EEG chain, decompression side. It accepts (run, value, end-of-block) tokens and expands each into a serial stream of 18-bit signed DCT coefficients, 8 per block, with index and last markers. The stream feeds the IDCT input buffer. It inverts the RLE stage that follows the Z0..Z7 DCT coefficient units.

## Interface
- COEF_W, 18: coefficient width; matches the DCT output width.
- RUN_W, 3: run-field width; a run of up to 7 zeros precedes a value.
- BLK_N, 8: coefficients per block. Fixed at 8; `out_idx` is 3 bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; state clears while reset==0.
- in_valid  in  1  token present.
- in_ready  out  1  token accepted on a cycle where in_valid && in_ready.
- in_run  in  RUN_W  number of zero coefficients before in_value.
- in_value  in  COEF_W signed  nonzero coefficient; ignored when in_eob=1.
- in_eob  in  1  end of block; zero-fill from the current position to index 7.
- out_valid  out  1  coefficient present.
- out_ready  in  1  downstream accepts on out_valid && out_ready.
- out_coef  out  COEF_W signed  coefficient.
- out_idx  out  3  coefficient position in the block, 0..7.
- out_last  out  1  high with out_idx==7.
- err  out  1  sticky overflow flag.

## Operation
- State: `pos` (next index, 0..7), `zcnt` (zeros left to emit), `hold_val` (pending value), FSM {IDLE, ZEROS, VALUE, FILL}.
- Output register: holds out_coef/out_idx/out_last/out_valid until taken. It loads only when `!out_valid || out_ready`; this condition is called "free".
- in_ready = (state==IDLE) && free.
- IDLE, token accepted, with "emit" meaning: load the output register and increment pos with wrap 7->0.
  - eob=0, run=0: emit in_value at pos; stay in IDLE.
  - eob=0, run>0: emit 0 at pos; hold_val<=in_value; zcnt<=run-1; go to ZEROS, or to VALUE if run==1.
  - eob=1: emit 0 at pos; if pos==7, stay in IDLE; otherwise go to FILL. in_run is ignored.
- ZEROS: on each free cycle emit 0 and decrement zcnt. When zcnt reaches 0, go to VALUE.
- VALUE: on a free cycle emit hold_val, then go to IDLE.
- FILL: on each free cycle emit 0. After the emit at index 7, go to IDLE.
- out_last = (emitted index == 7). A block closes automatically after index 7. An eob token arriving at pos 0 produces a full all-zero block.
- Overflow: a token with eob=0 and pos+run > 7 cannot place its value in the current block.
  - Set err.
  - Drop the value and go to FILL. The current block is zero-filled to index 7.
  - The next token starts a new block at pos 0.
- err stays high until reset. It has no other effect on operation.
- No stall is lost. While out_valid && !out_ready, all state holds and in_ready=0.

## Timing
- Reset (reset==0) gives:
  - Outputs: out_valid=0, out_coef=0, out_idx=0, out_last=0, err=0, in_ready=0.
  - State: state=IDLE, pos=0, zcnt=0, hold_val=0.
- in_ready rises on the first clock edge after reset is released.
- Reset mid-block discards the partial block. No out_last is produced for it.
- Latency: a token accepted at edge t presents its first coefficient from edge t, so it is visible in cycle t+1.
- Throughput: one coefficient per cycle while out_ready=1.
  - run-0 tokens: accepted back-to-back.
  - Token with run r: occupies r+1 output cycles; in_ready=0 for r cycles.
- Back-pressure: out_ready=0 freezes the FSM and the output register. out_coef, out_idx and out_last stay stable while out_valid=1.

## Structure
- Package `rle_pkg`:
  - constants BLK_N=8, COEF_W=18, RUN_W=3;
  - typedef `coef_t` (logic signed [17:0]);
  - enum `rle_state_t` {IDLE, ZEROS, VALUE, FILL}.
- Sub-module `rle_out_reg`: the output holding register with valid/ready and a load strobe. Reset to zero, asynchronous active-low.
- The top level contains the FSM, the pos/zcnt counters and the overflow check (pos+run computed 4 bits wide).

## Test plan
- Reset release, then tokens (0,5),(0,-3),(0,1),(0,2),(0,7),(0,-8),(0,4),(0,9) with out_ready=1 → coefficients 5,-3,1,2,7,-8,4,9 on consecutive cycles; idx 0..7; out_last only on 9; err=0.
- Tokens (2,100) then eob → out 0,0,100,0,0,0,0,0; out_last at idx 7; in_ready=0 for 2 cycles after the first accept.
- Single eob at pos 0 → eight zeros, idx 0..7, last on idx 7. A following (0,-1) → -1 at idx 0 of the next block.
- Tokens (0,1)×6 then (3,50) → idx 6,7 emit 0; 50 is dropped; err=1 and stays 1. The next token (0,2) → 2 at idx 0.
- (1,-20) with out_ready toggled 1,0,0,1,1 → sequence 0,-20 delivered once each; out_coef stable during the stalls.
- Reset asserted (0) at idx 4 of a block → all outputs 0 immediately. After release, (0,3) → 3 at idx 0; err=0.
